// File: rtl/rw_logic_sequencer.sv
// rtl/rw_logic_sequencer.sv - CPU write/read sequencer for ICW/OCW control words
// Commits a write when its strobe releases, steps the init FSM and multiplexes readback.
module rw_logic_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_select_bar,
    input  logic                  read_bar,
    input  logic                  write_bar,
    input  logic                  A0,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] irr_in,
    input  logic [DATA_WIDTH-1:0] isr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic                  ICW_1_flag,
    output logic                  ICW_2_flag,
    output logic                  ICW_3_flag,
    output logic                  ICW_4_flag,
    output logic                  OCW_1_flag,
    output logic                  OCW_2_flag,
    output logic                  OCW_3_flag,
    output logic [DATA_WIDTH-1:0] icw1_reg,
    output logic [DATA_WIDTH-1:0] icw2_reg,
    output logic [DATA_WIDTH-1:0] icw3_reg,
    output logic [DATA_WIDTH-1:0] icw4_reg,
    output logic [DATA_WIDTH-1:0] imr,
    output logic [DATA_WIDTH-1:0] ocw2_reg,
    output logic                  read_isr_sel,
    output logic                  init_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    localparam int F_ICW1 = 0;
    localparam int F_ICW2 = 1;
    localparam int F_ICW3 = 2;
    localparam int F_ICW4 = 3;
    localparam int F_OCW1 = 4;
    localparam int F_OCW2 = 5;
    localparam int F_OCW3 = 6;

    state_t                  state;
    state_t                  state_next;
    logic                    write_active;
    logic                    write_active_q;
    logic                    commit;
    logic                    cap_a0;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic [6:0]              flag_next;
    logic [6:0]              flag_q;

    assign write_active = ~chip_select_bar & ~write_bar;
    // Falling edge of the sampled strobe, however it was released.
    assign commit       = write_active_q & ~write_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_active_q <= 1'b0;
            cap_a0         <= 1'b0;
            cap_data       <= '0;
        end else begin
            write_active_q <= write_active;
            if (write_active) begin
                cap_a0   <= A0;
                cap_data <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        flag_next  = '0;
        if (commit) begin
            if (!cap_a0 && cap_data[4]) begin
                flag_next[F_ICW1] = 1'b1;
                state_next        = WAIT_ICW2;
            end else if (cap_a0) begin
                case (state)
                    WAIT_ICW2: begin
                        flag_next[F_ICW2] = 1'b1;
                        if (!icw1_reg[1]) begin
                            state_next = WAIT_ICW3;
                        end else if (icw1_reg[0]) begin
                            state_next = WAIT_ICW4;
                        end else begin
                            state_next = READY;
                        end
                    end
                    WAIT_ICW3: begin
                        flag_next[F_ICW3] = 1'b1;
                        state_next        = icw1_reg[0] ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: begin
                        flag_next[F_ICW4] = 1'b1;
                        state_next        = READY;
                    end
                    READY: begin
                        flag_next[F_OCW1] = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else if (state == READY) begin
                if (cap_data[3]) begin
                    flag_next[F_OCW3] = 1'b1;
                end else begin
                    flag_next[F_OCW2] = 1'b1;
                end
            end
        end
    end

    // Flags double as write enables so a word and its pulse land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q       <= '0;
            icw1_reg     <= '0;
            icw2_reg     <= '0;
            icw3_reg     <= '0;
            icw4_reg     <= '0;
            imr          <= '0;
            ocw2_reg     <= '0;
            read_isr_sel <= 1'b0;
        end else begin
            flag_q <= flag_next;
            if (flag_next[F_ICW1]) begin
                icw1_reg     <= cap_data;
                icw3_reg     <= '0;
                icw4_reg     <= '0;
                imr          <= '0;
                read_isr_sel <= 1'b0;
            end
            if (flag_next[F_ICW2]) begin
                icw2_reg <= cap_data;
            end
            if (flag_next[F_ICW3]) begin
                icw3_reg <= cap_data;
            end
            if (flag_next[F_ICW4]) begin
                icw4_reg <= cap_data;
            end
            if (flag_next[F_OCW1]) begin
                imr <= cap_data;
            end
            if (flag_next[F_OCW2]) begin
                ocw2_reg <= cap_data;
            end
            if (flag_next[F_OCW3] && cap_data[1]) begin
                read_isr_sel <= cap_data[0];
            end
        end
    end

    assign ICW_1_flag = flag_q[F_ICW1];
    assign ICW_2_flag = flag_q[F_ICW2];
    assign ICW_3_flag = flag_q[F_ICW3];
    assign ICW_4_flag = flag_q[F_ICW4];
    assign OCW_1_flag = flag_q[F_OCW1];
    assign OCW_2_flag = flag_q[F_OCW2];
    assign OCW_3_flag = flag_q[F_OCW3];
    assign init_done  = (state == READY);

    // A concurrent write strobe always wins over a read.
    assign data_oe = ~chip_select_bar & ~read_bar & ~write_active;

    always_comb begin
        data_out = '0;
        if (data_oe) begin
            if (A0) begin
                data_out = imr;
            end else if (read_isr_sel) begin
                data_out = isr_in;
            end else begin
                data_out = irr_in;
            end
        end
    end

endmodule

// File: tb/tb_rw_logic_sequencer.sv
// tb/tb_rw_logic_sequencer.sv - self-checking bench for rw_logic_sequencer
// Directed scenarios plus randomized traffic against a queue-based command model.
module tb_rw_logic_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       chip_select_bar, read_bar, write_bar, A0;
    logic [7:0] data_in, irr_in, isr_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       ICW_1_flag, ICW_2_flag, ICW_3_flag, ICW_4_flag;
    logic       OCW_1_flag, OCW_2_flag, OCW_3_flag;
    logic [7:0] icw1_reg, icw2_reg, icw3_reg, icw4_reg, imr, ocw2_reg;
    logic       read_isr_sel, init_done;

    logic [6:0]  flags;
    logic [49:0] dut_snap;

    int checks = 0;
    int passes = 0;

    // Behavioural model: the ICWs still owed after ICW1 sit in a queue.
    logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_imr, m_ocw2;
    logic       m_ris, m_ready;
    int         m_pending[$];

    rw_logic_sequencer #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .chip_select_bar(chip_select_bar), .read_bar(read_bar), .write_bar(write_bar),
        .A0(A0), .data_in(data_in), .irr_in(irr_in), .isr_in(isr_in),
        .data_out(data_out), .data_oe(data_oe),
        .ICW_1_flag(ICW_1_flag), .ICW_2_flag(ICW_2_flag), .ICW_3_flag(ICW_3_flag),
        .ICW_4_flag(ICW_4_flag), .OCW_1_flag(OCW_1_flag), .OCW_2_flag(OCW_2_flag),
        .OCW_3_flag(OCW_3_flag),
        .icw1_reg(icw1_reg), .icw2_reg(icw2_reg), .icw3_reg(icw3_reg), .icw4_reg(icw4_reg),
        .imr(imr), .ocw2_reg(ocw2_reg), .read_isr_sel(read_isr_sel), .init_done(init_done)
    );

    always #5 clk = ~clk;

    assign flags    = {OCW_3_flag, OCW_2_flag, OCW_1_flag, ICW_4_flag, ICW_3_flag, ICW_2_flag, ICW_1_flag};
    assign dut_snap = {icw1_reg, icw2_reg, icw3_reg, icw4_reg, imr, ocw2_reg, read_isr_sel, init_done};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_icw1 = 8'h00; m_icw2 = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
        m_imr = 8'h00; m_ocw2 = 8'h00; m_ris = 1'b0; m_ready = 1'b0;
        m_pending.delete();
    endfunction

    function automatic logic [6:0] model_write(input logic a0, input logic [7:0] d);
        logic [6:0] f;
        int         n;
        f = 7'b0;
        if (!a0 && d[4]) begin
            m_icw1 = d; m_imr = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
            m_ris = 1'b0; m_ready = 1'b0;
            m_pending.delete();
            m_pending.push_back(2);
            if (!d[1]) m_pending.push_back(3);
            if (d[0]) m_pending.push_back(4);
            f = 7'b0000001;
        end else if (a0) begin
            if (m_pending.size() > 0) begin
                n = m_pending.pop_front();
                case (n)
                    2:       begin m_icw2 = d; f = 7'b0000010; end
                    3:       begin m_icw3 = d; f = 7'b0000100; end
                    default: begin m_icw4 = d; f = 7'b0001000; end
                endcase
                if (m_pending.size() == 0) m_ready = 1'b1;
            end else if (m_ready) begin
                m_imr = d;
                f = 7'b0010000;
            end
        end else if (m_ready) begin
            if (!d[3]) begin
                m_ocw2 = d;
                f = 7'b0100000;
            end else begin
                if (d[1]) m_ris = d[0];
                f = 7'b1000000;
            end
        end
        return f;
    endfunction

    function automatic logic [49:0] model_snap();
        return {m_icw1, m_icw2, m_icw3, m_icw4, m_imr, m_ocw2, m_ris, m_ready};
    endfunction

    task automatic idle_bus();
        chip_select_bar = 1'b1; read_bar = 1'b1; write_bar = 1'b1;
    endtask

    // rel: 0 releases write_bar, 1 releases chip_select_bar, 2 releases both.
    task automatic do_write(input logic a0, input logic [7:0] d, input int hold, input int rel,
                            input logic rd, output logic [6:0] fl, output logic [6:0] fl_next,
                            output logic oe_w, output logic [7:0] do_w);
        @(posedge clk); #1;
        chip_select_bar = 1'b0; write_bar = 1'b0; read_bar = ~rd; A0 = a0; data_in = d;
        #1;
        oe_w = data_oe; do_w = data_out;
        repeat (hold) @(posedge clk);
        #1;
        if (rel != 1) write_bar = 1'b1;
        if (rel != 0) chip_select_bar = 1'b1;
        read_bar = 1'b1; A0 = ~a0; data_in = ~d;
        @(posedge clk); #1;
        fl = flags;
        idle_bus();
        @(posedge clk); #1;
        fl_next = flags;
    endtask

    task automatic do_read(input logic a0, input logic [7:0] irr, input logic [7:0] isr,
                           output logic [7:0] dout, output logic oe);
        @(posedge clk); #1;
        chip_select_bar = 1'b0; read_bar = 1'b0; write_bar = 1'b1;
        A0 = a0; irr_in = irr; isr_in = isr;
        #1;
        dout = data_out; oe = data_oe;
        #1;
        idle_bus();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        A0 = 1'b0; data_in = 8'h00; irr_in = 8'h00; isr_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (dut_snap !== 50'h0) $display("FAIL reset_regs: got %h want 0", dut_snap); else passes++;
        checks++; if (flags !== 7'h0) $display("FAIL reset_flags: got %b want 0", flags); else passes++;
        checks++; if (data_oe !== 1'b0 || data_out !== 8'h00) $display("FAIL reset_bus: oe %b out %h want 0/00", data_oe, data_out); else passes++;
    endtask

    task automatic test_icw_single();
        logic       a0_t [2] = '{1'b0, 1'b1};
        logic [7:0] d_t  [2] = '{8'h12, 8'h20};
        logic [6:0] ex_t [2] = '{7'b0000001, 7'b0000010};
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        for (int i = 0; i < 2; i++) begin
            do_write(a0_t[i], d_t[i], 1, 0, 1'b0, fl, fln, oe, dw);
            void'(model_write(a0_t[i], d_t[i]));
            checks++; if (fl !== ex_t[i]) $display("FAIL icw_single_flag%0d: got %b want %b", i, fl, ex_t[i]); else passes++;
            checks++; if (fln !== 7'h0) $display("FAIL icw_single_pulse%0d: got %b want 0", i, fln); else passes++;
        end
        checks++; if (icw2_reg !== 8'h20 || init_done !== 1'b1) $display("FAIL icw_single_state: icw2 %h done %b want 20/1", icw2_reg, init_done); else passes++;
        checks++; if (dut_snap !== model_snap()) $display("FAIL icw_single_regs: got %h want %h", dut_snap, model_snap()); else passes++;
    endtask

    task automatic test_icw_full();
        logic       a0_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] d_t  [4] = '{8'h11, 8'h08, 8'h04, 8'h01};
        logic [6:0] ex_t [4] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000};
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        for (int i = 0; i < 4; i++) begin
            do_write(a0_t[i], d_t[i], 1 + i % 2, i % 3, 1'b0, fl, fln, oe, dw);
            void'(model_write(a0_t[i], d_t[i]));
            checks++; if (fl !== ex_t[i]) $display("FAIL icw_full_flag%0d: got %b want %b", i, fl, ex_t[i]); else passes++;
        end
        checks++; if (icw3_reg !== 8'h04 || icw4_reg !== 8'h01 || init_done !== 1'b1) $display("FAIL icw_full_state: icw3 %h icw4 %h done %b want 04/01/1", icw3_reg, icw4_reg, init_done); else passes++;
        checks++; if (dut_snap !== model_snap()) $display("FAIL icw_full_regs: got %h want %h", dut_snap, model_snap()); else passes++;
    endtask

    task automatic test_ocw1_read();
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        do_write(1'b1, 8'hF0, 1, 2, 1'b0, fl, fln, oe, dw);
        void'(model_write(1'b1, 8'hF0));
        checks++; if (fl !== 7'b0010000) $display("FAIL ocw1_flag: got %b want 0010000", fl); else passes++;
        checks++; if (imr !== 8'hF0) $display("FAIL ocw1_imr: got %h want f0", imr); else passes++;
        do_read(1'b1, 8'h00, 8'h00, dw, oe);
        checks++; if (dw !== 8'hF0 || oe !== 1'b1) $display("FAIL ocw1_read: out %h oe %b want f0/1", dw, oe); else passes++;
    endtask

    task automatic test_ocw3_ocw2();
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        do_write(1'b0, 8'h0B, 1, 0, 1'b0, fl, fln, oe, dw);
        void'(model_write(1'b0, 8'h0B));
        checks++; if (fl !== 7'b1000000) $display("FAIL ocw3_flag: got %b want 1000000", fl); else passes++;
        do_read(1'b0, 8'hAA, 8'h55, dw, oe);
        checks++; if (dw !== 8'h55 || oe !== 1'b1) $display("FAIL ocw3_isr_read: out %h oe %b want 55/1", dw, oe); else passes++;
        do_write(1'b0, 8'h0A, 1, 1, 1'b0, fl, fln, oe, dw);
        void'(model_write(1'b0, 8'h0A));
        do_read(1'b0, 8'hAA, 8'h55, dw, oe);
        checks++; if (dw !== 8'hAA) $display("FAIL ocw3_irr_read: out %h want aa", dw); else passes++;
        do_write(1'b0, 8'h20, 2, 0, 1'b0, fl, fln, oe, dw);
        void'(model_write(1'b0, 8'h20));
        checks++; if (fl !== 7'b0100000 || ocw2_reg !== 8'h20) $display("FAIL ocw2: flag %b reg %h want 0100000/20", fl, ocw2_reg); else passes++;
    endtask

    task automatic test_reinit();
        logic       a0_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] d_t  [6] = '{8'h11, 8'h08, 8'h13, 8'h0B, 8'h30, 8'h03};
        logic [6:0] ex_t [6] = '{7'b0000001, 7'b0000010, 7'b0000001, 7'b0000000, 7'b0000010, 7'b0001000};
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        for (int i = 0; i < 6; i++) begin
            do_write(a0_t[i], d_t[i], 1, 0, 1'b0, fl, fln, oe, dw);
            void'(model_write(a0_t[i], d_t[i]));
            checks++; if (fl !== ex_t[i]) $display("FAIL reinit_flag%0d: got %b want %b", i, fl, ex_t[i]); else passes++;
            if (i == 2) begin
                checks++; if (imr !== 8'h00 || init_done !== 1'b0) $display("FAIL reinit_clear: imr %h done %b want 00/0", imr, init_done); else passes++;
            end
        end
        checks++; if (dut_snap !== model_snap()) $display("FAIL reinit_regs: got %h want %h", dut_snap, model_snap()); else passes++;
    endtask

    task automatic test_rw_collision();
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        do_write(1'b1, 8'h5A, 1, 2, 1'b1, fl, fln, oe, dw);
        void'(model_write(1'b1, 8'h5A));
        checks++; if (oe !== 1'b0 || dw !== 8'h00) $display("FAIL collision_bus: oe %b out %h want 0/00", oe, dw); else passes++;
        checks++; if (fl !== 7'b0010000 || imr !== 8'h5A) $display("FAIL collision_write: flag %b imr %h want 0010000/5a", fl, imr); else passes++;
    endtask

    task automatic test_reset_during_write();
        logic [6:0] seen;
        logic [6:0] fl, fln;
        logic       oe;
        logic [7:0] dw;
        @(posedge clk); #1;
        chip_select_bar = 1'b0; write_bar = 1'b0; A0 = 1'b0; data_in = 8'h12;
        @(posedge clk); #1;
        reset = 1'b1;
        #2 idle_bus();
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        seen = 7'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | flags;
        end
        checks++; if (seen !== 7'h0) $display("FAIL rst_write_flags: got %b want 0", seen); else passes++;
        checks++; if (dut_snap !== 50'h0 || data_oe !== 1'b0 || data_out !== 8'h00) $display("FAIL rst_write_state: regs %h oe %b out %h want 0", dut_snap, data_oe, data_out); else passes++;
        do_write(1'b0, 8'h0B, 1, 0, 1'b0, fl, fln, oe, dw);
        checks++; if (fl !== 7'h0) $display("FAIL idle_ocw3_ignored: got %b want 0", fl); else passes++;
        do_write(1'b1, 8'h44, 1, 0, 1'b0, fl, fln, oe, dw);
        checks++; if (fl !== 7'h0 || dut_snap !== 50'h0) $display("FAIL idle_a0_ignored: flag %b regs %h want 0", fl, dut_snap); else passes++;
    endtask

    task automatic test_strobe_across_reset();
        logic [6:0] seen;
        @(posedge clk); #1;
        reset = 1'b1;
        chip_select_bar = 1'b0; write_bar = 1'b0; A0 = 1'b0; data_in = 8'h12;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        seen = flags;
        repeat (2) @(posedge clk);
        #1;
        seen = seen | flags;
        idle_bus();
        checks++; if (seen !== 7'h0) $display("FAIL across_reset_early: got %b want 0", seen); else passes++;
        @(posedge clk); #1;
        void'(model_write(1'b0, 8'h12));
        checks++; if (flags !== 7'b0000001 || icw1_reg !== 8'h12) $display("FAIL across_reset_commit: flag %b icw1 %h want 0000001/12", flags, icw1_reg); else passes++;
    endtask

    task automatic test_random();
        logic       a0, rd, oe;
        logic [7:0] d, irr, isr, dw, ex_out;
        logic [6:0] fl, fln, ef;
        int         bad_flag = 0, bad_regs = 0, bad_read = 0;
        for (int i = 0; i < 300; i++) begin
            a0 = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                irr = 8'($urandom); isr = 8'($urandom);
                ex_out = a0 ? m_imr : (m_ris ? isr : irr);
                do_read(a0, irr, isr, dw, oe);
                checks++;
                if (dw !== ex_out || oe !== 1'b1) begin
                    bad_read++;
                    if (bad_read <= 5) $display("FAIL rand_read%0d: out %h oe %b want %h/1", i, dw, oe, ex_out);
                end else passes++;
            end else begin
                d = 8'($urandom);
                if (!a0 && $urandom_range(0, 4) != 0) d[4] = 1'b0;
                rd = ($urandom_range(0, 5) == 0);
                do_write(a0, d, $urandom_range(1, 3), $urandom_range(0, 2), rd, fl, fln, oe, dw);
                ef = model_write(a0, d);
                checks++;
                if (fl !== ef || fln !== 7'h0) begin
                    bad_flag++;
                    if (bad_flag <= 5) $display("FAIL rand_flag%0d: got %b then %b want %b then 0", i, fl, fln, ef);
                end else passes++;
                checks++;
                if (dut_snap !== model_snap()) begin
                    bad_regs++;
                    if (bad_regs <= 5) $display("FAIL rand_regs%0d: got %h want %h", i, dut_snap, model_snap());
                end else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_icw_single();
        test_reset();
        test_icw_full();
        test_ocw1_read();
        test_ocw3_ocw2();
        test_reinit();
        test_rw_collision();
        test_reset_during_write();
        test_strobe_across_reset();
        test_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
